// File: rtl/otter_io_pkg.sv
// Shared definitions for OTTER IOBUS peripherals: register word offsets,
// CTRL field positions and the packed CTRL register type.
package otter_io_pkg;

    // Word offsets (IOBUS_ADDR[3:2]) of the timer registers.
    localparam logic [1:0] OFF_CTRL   = 2'd0;  // byte offset 0x0
    localparam logic [1:0] OFF_LOAD   = 2'd1;  // byte offset 0x4
    localparam logic [1:0] OFF_COUNT  = 2'd2;  // byte offset 0x8
    localparam logic [1:0] OFF_STATUS = 2'd3;  // byte offset 0xC

    // CTRL bit positions.
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_AUTO_BIT  = 1;
    localparam int CTRL_IE_BIT    = 2;
    localparam int CTRL_PRESC_LSB = 8;
    localparam int CTRL_PRESC_MSB = 15;

    typedef struct packed {
        logic [7:0] presc;
        logic       ie;
        logic       auto_reload;
        logic       en;
    } ctrl_t;

    // Extract the implemented CTRL fields from a bus word; reserved bits drop.
    function automatic ctrl_t ctrl_from_word(input logic [31:0] w);
        ctrl_t c;
        c.presc       = w[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
        c.ie          = w[CTRL_IE_BIT];
        c.auto_reload = w[CTRL_AUTO_BIT];
        c.en          = w[CTRL_EN_BIT];
        return c;
    endfunction

    // Place CTRL fields back at their bus positions; reserved bits read 0.
    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = c.presc;
        w[CTRL_IE_BIT]                   = c.ie;
        w[CTRL_AUTO_BIT]                 = c.auto_reload;
        w[CTRL_EN_BIT]                   = c.en;
        return w;
    endfunction

endpackage

// File: rtl/otter_tick_prescaler.sv
// Programmable tick divider: pulses tick for one cycle every presc+1 cycles
// while enabled. If presc is lowered below the current count, the counter
// runs on through its natural 8-bit wrap before matching again.
module otter_tick_prescaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clear,
    input  logic [7:0] presc,
    output logic       tick
);

    logic [7:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == presc);

    // Next count: advance while enabled, return to zero on tick, stop or clear.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q + 8'd1;
        if (!enable || clear || tick) begin
            cnt_d = '0;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/otter_iobus_timer.sv
// Memory-mapped down-counting timer on the OTTER IOBUS: CTRL/LOAD/COUNT/STATUS
// registers, prescaled tick, one-shot or auto-reload expiry and a level IRQ.
// The counter is in RUN exactly when CTRL.EN is set, IDLE otherwise.
module otter_iobus_timer
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR
);

    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic [31:0] rdata_q, rdata_d;
    logic        exp_q, exp_d;

    logic        hit;
    logic [1:0]  offset;
    logic        wr_ctrl, wr_load, wr_status;
    logic        presc_clear;
    logic        tick;
    logic        expire;
    logic        addr_lsb_unused;

    // Byte-lane bits are not decoded; registers are word-wide only.
    assign addr_lsb_unused = ^IOBUS_ADDR[1:0];

    assign hit       = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign offset    = IOBUS_ADDR[3:2];
    assign wr_ctrl   = IOBUS_WR && hit && (offset == OFF_CTRL);
    assign wr_load   = IOBUS_WR && hit && (offset == OFF_LOAD);
    assign wr_status = IOBUS_WR && hit && (offset == OFF_STATUS);

    // Restart the tick phase when software turns the timer on.
    assign presc_clear = wr_ctrl && !ctrl_q.en && IOBUS_OUT[CTRL_EN_BIT];

    otter_tick_prescaler u_presc (
        .clk    (CLOCK),
        .rst_n  (RESET),
        .enable (ctrl_q.en),
        .clear  (presc_clear),
        .presc  (ctrl_q.presc),
        .tick   (tick)
    );

    assign expire = tick && (count_q == '0);

    // Register next state: tick processing first, then bus writes override.
    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        exp_d   = exp_q;

        // Tick is evaluated against the pre-write CTRL; COUNT stops at zero.
        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 32'd1;
            end else if (ctrl_q.auto_reload) begin
                count_d = load_q;
            end else begin
                ctrl_d.en = 1'b0;
            end
        end

        // A written CTRL replaces whatever the expiry did to EN.
        if (wr_ctrl) begin
            ctrl_d = ctrl_from_word(IOBUS_OUT);
        end

        // LOAD writes also seed COUNT, beating a same-cycle decrement/reload.
        if (wr_load) begin
            load_d  = IOBUS_OUT;
            count_d = IOBUS_OUT;
        end

        // Write-1-to-clear, but a coincident expiry keeps EXP set.
        if (wr_status && IOBUS_OUT[0]) begin
            exp_d = 1'b0;
        end
        if (expire) begin
            exp_d = 1'b1;
        end
    end

    // Read mux for the addressed register; undecoded addresses read zero.
    always_comb begin
        rdata_d = '0;
        if (hit) begin
            case (offset)
                OFF_CTRL:   rdata_d = ctrl_to_word(ctrl_q);
                OFF_LOAD:   rdata_d = load_q;
                OFF_COUNT:  rdata_d = count_q;
                OFF_STATUS: rdata_d = {31'd0, exp_q};
                default:    rdata_d = '0;
            endcase
        end
    end

    // State and read-data registers with synchronous active-low reset.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            exp_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            exp_q   <= exp_d;
            rdata_q <= rdata_d;
        end
    end

    assign IOBUS_IN = rdata_q;
    assign INTR     = exp_q & ctrl_q.ie;

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Directed self-checking bench for otter_iobus_timer.
module tb_otter_iobus_timer;

    localparam logic [31:0] A_CTRL   = 32'h1100_0100;
    localparam logic [31:0] A_LOAD   = 32'h1100_0104;
    localparam logic [31:0] A_COUNT  = 32'h1100_0108;
    localparam logic [31:0] A_STATUS = 32'h1100_010C;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic        INTR;

    int vectors    = 0;
    int miscompares = 0;

    otter_iobus_timer dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .INTR       (INTR)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        IOBUS_WR   = 1'b1;
        step();
        IOBUS_WR   = 1'b0;
        IOBUS_OUT  = '0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        IOBUS_ADDR = addr;
        IOBUS_WR   = 1'b0;
        step();
        data = IOBUS_IN;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        RESET = 1'b0;
        step();
        step();
        vectors++;
        if (IOBUS_IN !== 32'h0 || INTR !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: IOBUS_IN=%h INTR=%b, expected 0/0", IOBUS_IN, INTR);
        end
        RESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_read(A_CTRL + 32'(4 * i), rd);
            vectors++;
            if (rd !== 32'h0 || INTR !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_read_%0d: data=%h INTR=%b, expected 0/0", i, rd, INTR);
            end
        end
    endtask

    task automatic test_ctrl_fields();
        logic [31:0] rd;
        bus_write(A_CTRL, 32'hFFFF_00F8);
        bus_read(A_CTRL, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL ctrl_reserved: got %h, expected %h", rd, 32'h0);
        end
        bus_write(A_CTRL, 32'hA5A5_A5A6);
        bus_read(A_CTRL, rd);
        vectors++;
        if (rd !== 32'h0000_A506) begin
            miscompares++;
            $display("FAIL ctrl_fields: got %h, expected %h", rd, 32'h0000_A506);
        end
        bus_write(32'h1100_0200, 32'h0000_0000);
        bus_read(A_CTRL, rd);
        vectors++;
        if (rd !== 32'h0000_A506) begin
            miscompares++;
            $display("FAIL undecoded_write: CTRL=%h, expected %h", rd, 32'h0000_A506);
        end
        bus_read(32'h1100_0110, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL undecoded_read: got %h, expected %h", rd, 32'h0);
        end
        bus_write(A_CTRL, 32'h0);
        bus_write(A_LOAD, 32'hDEAD_BEEF);
        bus_read(A_LOAD, rd);
        vectors++;
        if (rd !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL load_readback: got %h, expected %h", rd, 32'hDEAD_BEEF);
        end
        bus_read(A_COUNT, rd);
        vectors++;
        if (rd !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL load_seeds_count: got %h, expected %h", rd, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        logic [31:0] exp_rd [4] = '{32'd3, 32'd2, 32'd1, 32'd0};
        logic        exp_irq[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        bus_write(A_LOAD, 32'd3);
        bus_write(A_CTRL, 32'h0000_0005);
        IOBUS_ADDR = A_COUNT;
        // Registered read shows the pre-edge COUNT: 3, then 2, 1, 0; expiry on 4th tick.
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (IOBUS_IN !== exp_rd[i] || INTR !== exp_irq[i]) begin
                miscompares++;
                $display("FAIL oneshot_cycle_%0d: COUNT=%h INTR=%b, expected %h/%b",
                         i, IOBUS_IN, INTR, exp_rd[i], exp_irq[i]);
            end
        end
        bus_read(A_CTRL, rd);
        vectors++;
        if (rd !== 32'h0000_0004) begin
            miscompares++;
            $display("FAIL oneshot_en_cleared: CTRL=%h, expected %h", rd, 32'h4);
        end
        bus_read(A_COUNT, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL oneshot_count_hold: COUNT=%h, expected %h", rd, 32'h0);
        end
        bus_read(A_STATUS, rd);
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("FAIL oneshot_status: STATUS=%h, expected %h", rd, 32'h1);
        end
        bus_write(A_STATUS, 32'h1);
        vectors++;
        if (INTR !== 1'b0) begin
            miscompares++;
            $display("FAIL oneshot_w1c: INTR=%b, expected 0", INTR);
        end
        bus_write(A_CTRL, 32'h0);
    endtask

    task automatic test_auto_reload();
        logic [31:0] rd;
        logic        early;
        bus_write(A_LOAD, 32'd1);
        bus_write(A_CTRL, 32'h0000_0307);
        IOBUS_ADDR = A_STATUS;
        early = 1'b0;
        repeat (7) begin
            step();
            if (INTR === 1'b1) early = 1'b1;
        end
        vectors++;
        if (early !== 1'b0) begin
            miscompares++;
            $display("FAIL auto_early_irq: INTR seen=%b in first 7 cycles, expected 0", early);
        end
        step();
        vectors++;
        if (INTR !== 1'b1) begin
            miscompares++;
            $display("FAIL auto_first_expiry: INTR=%b at cycle 8, expected 1", INTR);
        end
        bus_write(A_STATUS, 32'h1);
        vectors++;
        if (INTR !== 1'b0) begin
            miscompares++;
            $display("FAIL auto_w1c: INTR=%b, expected 0", INTR);
        end
        repeat (6) step();
        vectors++;
        if (INTR !== 1'b0) begin
            miscompares++;
            $display("FAIL auto_gap: INTR=%b at cycle 15, expected 0", INTR);
        end
        step();
        vectors++;
        if (INTR !== 1'b1) begin
            miscompares++;
            $display("FAIL auto_second_expiry: INTR=%b at cycle 16, expected 1", INTR);
        end
        // W1C landing on the cycle-24 expiry: set must win.
        bus_write(A_STATUS, 32'h1);
        vectors++;
        if (INTR !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_pre_clear: INTR=%b, expected 0", INTR);
        end
        repeat (6) step();
        bus_write(A_STATUS, 32'h1);
        vectors++;
        if (INTR !== 1'b1) begin
            miscompares++;
            $display("FAIL w1c_vs_expiry: INTR=%b, expected 1", INTR);
        end
        bus_read(A_STATUS, rd);
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("FAIL w1c_vs_expiry_status: STATUS=%h, expected %h", rd, 32'h1);
        end
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h1);
    endtask

    task automatic test_auto_zero();
        logic [31:0] rd;
        bus_write(A_LOAD, 32'd0);
        bus_write(A_CTRL, 32'h0000_0003);
        bus_read(A_STATUS, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_status_before: STATUS=%h, expected %h", rd, 32'h0);
        end
        bus_write(A_STATUS, 32'h1);
        bus_read(A_STATUS, rd);
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("FAIL zero_every_tick: STATUS=%h, expected %h", rd, 32'h1);
        end
        bus_read(A_COUNT, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_no_underflow: COUNT=%h, expected %h", rd, 32'h0);
        end
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h1);
        bus_read(A_STATUS, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_cleanup: STATUS=%h, expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_ctrl_vs_tick();
        logic [31:0] rd;
        bus_write(A_LOAD, 32'd0);
        bus_write(A_CTRL, 32'h0000_0001);
        // Expiry on this edge would clear EN; the written EN=1 must win.
        bus_write(A_CTRL, 32'h0000_0005);
        vectors++;
        if (INTR !== 1'b1) begin
            miscompares++;
            $display("FAIL ctrl_tick_irq: INTR=%b, expected 1", INTR);
        end
        bus_read(A_CTRL, rd);
        vectors++;
        if (rd !== 32'h0000_0005) begin
            miscompares++;
            $display("FAIL ctrl_tick_en_wins: CTRL=%h, expected %h", rd, 32'h5);
        end
        bus_read(A_CTRL, rd);
        vectors++;
        if (rd !== 32'h0000_0004) begin
            miscompares++;
            $display("FAIL ctrl_tick_next_expiry: CTRL=%h, expected %h", rd, 32'h4);
        end
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h1);
    endtask

    task automatic test_load_priority();
        logic [31:0] rd;
        bus_write(A_LOAD, 32'd6);
        bus_write(A_CTRL, 32'h0000_0001);
        step();                           // COUNT 6 -> 5
        bus_write(A_LOAD, 32'h10);        // tick with COUNT=5 on this edge
        bus_read(A_COUNT, rd);
        vectors++;
        if (rd !== 32'h10) begin
            miscompares++;
            $display("FAIL load_beats_tick: COUNT=%h, expected %h", rd, 32'h10);
        end
        bus_write(A_CTRL, 32'h0);         // last tick: 0xF -> 0xE
        bus_write(A_COUNT, 32'h55);
        bus_read(A_COUNT, rd);
        vectors++;
        if (rd !== 32'hE) begin
            miscompares++;
            $display("FAIL count_read_only: COUNT=%h, expected %h", rd, 32'hE);
        end
        bus_read(A_LOAD, rd);
        vectors++;
        if (rd !== 32'h10) begin
            miscompares++;
            $display("FAIL load_value: LOAD=%h, expected %h", rd, 32'h10);
        end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] rd;
        logic        irq_seen;
        bus_write(A_LOAD, 32'd7);
        bus_write(A_CTRL, 32'h0000_FF05);
        bus_read(A_COUNT, rd);
        vectors++;
        if (rd !== 32'd7) begin
            miscompares++;
            $display("FAIL midcount_setup: COUNT=%h, expected %h", rd, 32'd7);
        end
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        vectors++;
        if (IOBUS_IN !== 32'h0 || INTR !== 1'b0) begin
            miscompares++;
            $display("FAIL midcount_reset_out: IOBUS_IN=%h INTR=%b, expected 0/0", IOBUS_IN, INTR);
        end
        irq_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_read(A_CTRL + 32'(4 * i), rd);
            if (INTR === 1'b1) irq_seen = 1'b1;
            vectors++;
            if (rd !== 32'h0) begin
                miscompares++;
                $display("FAIL midcount_read_%0d: data=%h, expected %h", i, rd, 32'h0);
            end
        end
        IOBUS_ADDR = A_STATUS;
        repeat (300) begin
            step();
            if (INTR === 1'b1) irq_seen = 1'b1;
        end
        vectors++;
        if (irq_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL midcount_no_irq: INTR seen=%b, expected 0", irq_seen);
        end
    endtask

    initial begin
        RESET      = 1'b0;
        IOBUS_ADDR = '0;
        IOBUS_OUT  = '0;
        IOBUS_WR   = 1'b0;
        test_reset();
        test_ctrl_fields();
        test_oneshot();
        test_auto_reload();
        test_auto_zero();
        test_ctrl_vs_tick();
        test_load_priority();
        test_reset_midcount();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
